regfile_write_queue: RTL and testbench

REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

---
 rtl/regfile_write_queue.sv | 109 ++++++++++
 tb/tb_regfile_write_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// Four-entry FIFO of register-file writes, drained one per cycle into registered RW/BusW/RegWr.
// Optional macro RF_ZERO_REG_DROP_EN: requests to register 31 are accepted but not enqueued.
module regfile_write_queue (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  InReg,
  input  logic [63:0] InData,
  input  logic        Stall,
  input  logic        Flush,
  output logic [4:0]  RW,
  output logic [63:0] BusW,
  output logic        RegWr,
  output logic [2:0]  Count
);

  typedef enum logic [1:0] {StIdle, StDrain, StHold} state_e;

  state_e      state_q, state_d;
  logic [1:0]  wptr_q, wptr_d;
  logic [1:0]  rptr_q, rptr_d;
  logic [2:0]  count_q, count_d;
  logic [4:0]  rw_q, rw_d;
  logic [63:0] busw_q, busw_d;
  logic        regwr_q, regwr_d;

  logic [4:0]  reg_mem_q  [4];
  logic [63:0] data_mem_q [4];

  logic push, enq, pop;

  assign InReady = (count_q < 3'd4);
  assign push    = InValid && InReady && !Flush;
`ifdef RF_ZERO_REG_DROP_EN
  assign enq     = push && (InReg != 5'd31);
`else
  assign enq     = push;
`endif
  assign pop     = (count_q != 3'd0) && !Stall && !Flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rw_d    = rw_q;
    busw_d  = busw_q;
    regwr_d = pop;
    state_d = state_q;
    if (Flush) begin
      // Realign pointers so the empty queue keeps rptr == wptr.
      wptr_d  = 2'd0;
      rptr_d  = 2'd0;
      count_d = 3'd0;
    end else begin
      if (enq) wptr_d = wptr_q + 2'd1;
      if (pop) begin
        rptr_d = rptr_q + 2'd1;
        rw_d   = reg_mem_q[rptr_q];
        busw_d = data_mem_q[rptr_q];
      end
      count_d = count_q + {2'b00, enq} - {2'b00, pop};
    end
    if (count_d == 3'd0) begin
      state_d = StIdle;
    end else if (Stall) begin
      state_d = StHold;
    end else begin
      state_d = StDrain;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
      rw_q    <= 5'd0;
      busw_q  <= 64'd0;
      regwr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
      regwr_q <= regwr_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (enq) begin
      reg_mem_q[wptr_q]  <= InReg;
      data_mem_q[wptr_q] <= InData;
    end
  end

  // The state encoding must always agree with the occupancy count.
  state_matches_count_a: assert property (@(posedge Clk) disable iff (!Rst_n)
    (state_q == StIdle) == (count_q == 3'd0));

  assign RW    = rw_q;
  assign BusW  = busw_q;
  assign RegWr = regwr_q;
  assign Count = count_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue: expected writes queued at push time, monitor compares.
module tb_regfile_write_queue;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [4:0]  InReg = 5'd0;
  logic [63:0] InData = 64'd0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic        RegWr;
  logic [2:0]  Count;

  int checks = 0;
  int errors = 0;
  logic [68:0] exp_q[$];
  logic [68:0] mon_e;

  regfile_write_queue dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .InValid(InValid),
    .InReady(InReady),
    .InReg  (InReg),
    .InData (InData),
    .Stall  (Stall),
    .Flush  (Flush),
    .RW     (RW),
    .BusW   (BusW),
    .RegWr  (RegWr),
    .Count  (Count)
  );

  always #5 Clk = ~Clk;

  // Monitor: every write the DUT issues must match the oldest expected entry.
  always @(negedge Clk) begin
    if (Rst_n && RegWr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual RW=%0d BusW=%0d required no write", RW, BusW);
      end else begin
        mon_e = exp_q.pop_front();
        if ({RW, BusW} !== mon_e) begin
          errors++;
          $display("FAIL write_data actual RW=%0d BusW=%0d required RW=%0d BusW=%0d",
                   RW, BusW, mon_e[68:64], mon_e[63:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [63:0] d);
    InValid = v;
    InReg   = r;
    InData  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 Rst_n = 1'b0;
    #1;
    chk("reset_count", 64'(Count), 64'd0);
    chk("reset_regwr", 64'(RegWr), 64'd0);
    chk("reset_rw", 64'(RW), 64'd0);
    chk("reset_busw", BusW, 64'd0);
    tick();
    tick();
    Rst_n = 1'b1;
    chk("inready_after_reset", 64'(InReady), 64'd1);

    // Single write: RegWr exactly one cycle, two edges after the push.
    drive(1'b1, 5'd2, 64'd3456);
    exp_q.push_back({5'd2, 64'd3456});
    tick();
    drive(1'b0, 5'd0, 64'd0);
    chk("single_count_after_push", 64'(Count), 64'd1);
    chk("single_regwr_edge_n", 64'(RegWr), 64'd0);
    tick();
    chk("single_regwr_edge_n1", 64'(RegWr), 64'd1);
    chk("single_count_after_pop", 64'(Count), 64'd0);
    tick();
    chk("single_regwr_edge_n2", 64'(RegWr), 64'd0);
    chk("single_rw_hold", 64'(RW), 64'd2);

    // Full with Stall: fifth request refused.
    Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 1), 64'((i + 1) * 10));
      chk("full_inready", 64'(InReady), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) exp_q.push_back({5'(i + 1), 64'((i + 1) * 10)});
      tick();
    end
    drive(1'b0, 5'd0, 64'd0);
    chk("full_count", 64'(Count), 64'd4);
    chk("full_inready_low", 64'(InReady), 64'd0);
    Stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_burst_regwr", 64'(RegWr), 64'd1);
      chk("drain_burst_count", 64'(Count), 64'(3 - k));
    end
    tick();
    chk("drain_burst_end", 64'(RegWr), 64'd0);

    // Back-to-back stream wraps the pointers; one write per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(i), 64'(100 + i));
      exp_q.push_back({5'(i), 64'(100 + i)});
      tick();
      chk("stream_count", 64'(Count), 64'd1);
      chk("stream_regwr", 64'(RegWr), (i > 0) ? 64'd1 : 64'd0);
    end
    drive(1'b0, 5'd0, 64'd0);
    tick();
    chk("stream_last_regwr", 64'(RegWr), 64'd1);
    chk("stream_last_count", 64'(Count), 64'd0);
    tick();
    chk("stream_end_regwr", 64'(RegWr), 64'd0);

    // Flush overrides a simultaneous push; flushed entries never written.
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(11 + i), 64'(500 + i));
      tick();
    end
    chk("flush_pre_count", 64'(Count), 64'd3);
    drive(1'b1, 5'd7, 64'd777);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    drive(1'b0, 5'd0, 64'd0);
    chk("flush_count", 64'(Count), 64'd0);
    chk("flush_regwr", 64'(RegWr), 64'd0);
    chk("flush_rw_hold", 64'(RW), 64'd9);
    chk("flush_busw_hold", BusW, 64'd109);
    Stall = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("flush_no_write", 64'(RegWr), 64'd0);
    end

    // Register 31 handling.
    drive(1'b1, 5'd19, 64'd6453);
    exp_q.push_back({5'd19, 64'd6453});
    tick();
    drive(1'b1, 5'd31, 64'd6453);
`ifndef RF_ZERO_REG_DROP_EN
    exp_q.push_back({5'd31, 64'd6453});
`endif
    tick();
    drive(1'b0, 5'd0, 64'd0);
    chk("zero_reg_first_write", 64'(RegWr), 64'd1);
`ifdef RF_ZERO_REG_DROP_EN
    chk("zero_reg_count", 64'(Count), 64'd0);
`else
    chk("zero_reg_count", 64'(Count), 64'd1);
`endif
    repeat (4) tick();

    // Reset mid-queue: in-flight and queued entries discarded.
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(21 + i), 64'(i + 1));
      tick();
    end
    drive(1'b0, 5'd0, 64'd0);
    chk("midreset_pre_count", 64'(Count), 64'd3);
    exp_q.push_back({5'd21, 64'd1});
    Stall = 1'b0;
    tick();
    chk("midreset_regwr_before", 64'(RegWr), 64'd1);
    chk("midreset_count_before", 64'(Count), 64'd2);
    @(negedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    chk("midreset_count", 64'(Count), 64'd0);
    chk("midreset_regwr", 64'(RegWr), 64'd0);
    chk("midreset_rw", 64'(RW), 64'd0);
    chk("midreset_busw", BusW, 64'd0);
    tick();
    tick();
    Rst_n = 1'b1;
    chk("midreset_inready", 64'(InReady), 64'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("midreset_no_write", 64'(RegWr), 64'd0);
    end

    chk("scoreboard_pending", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
